// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module : i2s_pkg
// Brief  : Shared widths, counter limits and frame/channel helpers for the I2S path.
// Rev    : 1.0
// ============================================================================
package i2s_pkg;

    localparam int              AUDIO_DW_DEFAULT = 32;
    localparam int              CNT_W            = 16;
    localparam logic [CNT_W-1:0] CNT_MAX         = 16'hFFFF;

    function automatic int frame_w(input int num_ch, input int dw);
        return num_ch * dw;
    endfunction

    // LSB position of channel ch inside a packed frame.
    function automatic int ch_lsb(input int ch, input int dw);
        return ch * dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module : i2s_sat_cnt
// Brief  : CNT_W-bit saturating event counter with synchronous clear.
// Rev    : 1.0
// ============================================================================
module i2s_sat_cnt
    import i2s_pkg::*;
(
    input  logic             lrclk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Clear takes priority over a same-cycle increment.
    always_ff @(posedge lrclk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/i2s_frame_fifo.sv
`default_nettype none
// ============================================================================
// Module : i2s_frame_fifo
// Brief  : Multi-channel elastic frame buffer between I2S rx and tx word paths.
// Rev    : 1.0
// ============================================================================
module i2s_frame_fifo
    import i2s_pkg::*;
#(
    parameter int AUDIO_DW = AUDIO_DW_DEFAULT,
    parameter int NUM_CH   = 2,
    parameter int DEPTH    = 8
) (
    input  logic                         lrclk,
    input  logic                         rst,
    input  logic [NUM_CH*AUDIO_DW-1:0]   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [NUM_CH*AUDIO_DW-1:0]   out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         underrun_hold,
    input  logic                         clr_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [CNT_W-1:0]             overflow_cnt,
    output logic [CNT_W-1:0]             underrun_cnt
);

    localparam int FW = frame_w(NUM_CH, AUDIO_DW);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(DEPTH + 1);

    logic [FW-1:0] r_mem [DEPTH];
    logic [FW-1:0] r_last;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_diff;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = in_valid && !w_full;
    assign w_pop   = out_ready && !w_empty;
    assign w_diff  = r_wr_ptr - r_rd_ptr;

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign level     = LW'(w_diff);

    always_ff @(posedge lrclk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_last   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_last   <= r_mem[r_rd_ptr[AW-1:0]];
            end
        end
    end

    // Storage is deliberately unreset; the empty-fill mux below hides it.
    always_ff @(posedge lrclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= in_data;
        end
    end

    always_comb begin
        out_data = '0;
        if (!w_empty) begin
            out_data = r_mem[r_rd_ptr[AW-1:0]];
        end else if (underrun_hold) begin
            out_data = r_last;
        end
    end

    i2s_sat_cnt u_overflow_cnt (
        .lrclk (lrclk),
        .rst   (rst),
        .i_inc (in_valid && w_full),
        .i_clr (clr_cnt),
        .o_cnt (overflow_cnt)
    );

    i2s_sat_cnt u_underrun_cnt (
        .lrclk (lrclk),
        .rst   (rst),
        .i_inc (out_ready && w_empty),
        .i_clr (clr_cnt),
        .o_cnt (underrun_cnt)
    );

endmodule
`default_nettype wire
